// File: rtl/arb_pkg.sv
// Shared encodings for the system bus arbiter: FSM states and well-known master indices.
package arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_RELEASE = 2'd2
   } arb_state_t;

   localparam int CPU_IDX = 0;
   localparam int DMA_IDX = 1;

endpackage

// File: rtl/rr_pick.sv
// Combinational winner selection: lowest set index (fixed) or first set bit after ptr (round-robin).
module rr_pick #(
   parameter int NREQ    = 2,
   parameter int OWNER_W = 1
) (
   input  logic [NREQ-1:0]    req,
   input  logic [OWNER_W-1:0] ptr,
   input  logic               fixed,
   output logic [OWNER_W-1:0] winner,
   output logic               valid
);

   always_comb begin
      int w_idx;
      winner = '0;
      valid  = 1'b0;
      w_idx  = 0;
      for (int k = 0; k < NREQ; k++) begin
         w_idx = fixed ? k : ((int'(ptr) + 1 + k) % NREQ);
         if (!valid && req[w_idx]) begin
            valid  = 1'b1;
            winner = OWNER_W'(w_idx);
         end
      end
   end

endmodule

// File: rtl/sys_bus_arbiter.sv
// Shared system bus arbiter: single owner at a time, one dead cycle between owners,
// watchdog revokes a grant that sees no ready for TIMEOUT cycles.
module sys_bus_arbiter
   import arb_pkg::*;
#(
   parameter int NREQ       = 2,
   parameter int FIXED_PRIO = 0,
   parameter int TIMEOUT    = 255,
   parameter int OWNER_W    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req,
   input  logic               ready,
   output logic [NREQ-1:0]    grant,
   output logic [OWNER_W-1:0] owner,
   output logic               bus_busy,
   output logic               xfer_done,
   output logic               timeout_err
);

   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

   arb_state_t         r_state, w_state_nxt;
   logic [NREQ-1:0]    r_grant, w_grant_nxt;
   logic [OWNER_W-1:0] r_owner, w_owner_nxt;
   logic [OWNER_W-1:0] r_ptr, w_ptr_nxt;
   logic [WD_W-1:0]    r_wd, w_wd_nxt;
   logic               r_xfer_done, w_xfer_nxt;
   logic               r_timeout, w_to_nxt;
   logic [OWNER_W-1:0] w_winner;
   logic               w_valid;
   logic               w_fixed;
   logic [WD_W-1:0]    w_wd_inc;

   function automatic logic [WD_W-1:0] wd_sat_inc(input logic [WD_W-1:0] v);
      return (v == WD_MAX) ? v : v + 1'b1;
   endfunction

   assign w_fixed  = (FIXED_PRIO != 0);
   assign w_wd_inc = wd_sat_inc(r_wd);

   rr_pick #(
      .NREQ    (NREQ),
      .OWNER_W (OWNER_W)
   ) u_pick (
      .req    (req),
      .ptr    (r_ptr),
      .fixed  (w_fixed),
      .winner (w_winner),
      .valid  (w_valid)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_owner_nxt = r_owner;
      w_ptr_nxt   = r_ptr;
      w_wd_nxt    = r_wd;
      w_xfer_nxt  = 1'b0;
      w_to_nxt    = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_valid) begin
               w_state_nxt = ST_GRANT;
               w_grant_nxt = {{(NREQ-1){1'b0}}, 1'b1} << w_winner;
               w_owner_nxt = w_winner;
               w_ptr_nxt   = w_winner;
               w_wd_nxt    = '0;
            end
         end
         ST_GRANT: begin
            // Completion beats both abort and watchdog when they coincide.
            if (ready) begin
               w_state_nxt = ST_RELEASE;
               w_grant_nxt = '0;
               w_xfer_nxt  = 1'b1;
            end else if (!req[r_owner]) begin
               w_state_nxt = ST_RELEASE;
               w_grant_nxt = '0;
            end else if (w_wd_inc == WD_MAX) begin
               w_state_nxt = ST_RELEASE;
               w_grant_nxt = '0;
               w_to_nxt    = 1'b1;
               w_wd_nxt    = w_wd_inc;
            end else begin
               w_wd_nxt = w_wd_inc;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_grant     <= '0;
         r_owner     <= '0;
         r_ptr       <= OWNER_W'(NREQ - 1);
         r_wd        <= '0;
         r_xfer_done <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_grant     <= w_grant_nxt;
         r_owner     <= w_owner_nxt;
         r_ptr       <= w_ptr_nxt;
         r_wd        <= w_wd_nxt;
         r_xfer_done <= w_xfer_nxt;
         r_timeout   <= w_to_nxt;
      end
   end

   assign grant       = r_grant;
   assign owner       = r_owner;
   assign bus_busy    = |r_grant;
   assign xfer_done   = r_xfer_done;
   assign timeout_err = r_timeout;

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Directed vector bench for sys_bus_arbiter: round-robin/watchdog instance and fixed-priority instance.
module tb_sys_bus_arbiter;

   typedef struct packed {
      logic [1:0] req;
      logic       rdy;
      logic [1:0] gnt;
      logic       xd;
      logic       to;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic [1:0] rr_req = 2'b00;
   logic       rr_ready = 1'b0;
   logic [1:0] rr_grant;
   logic [0:0] rr_owner;
   logic       rr_busy, rr_xd, rr_to;

   logic [1:0] fx_req = 2'b00;
   logic       fx_ready = 1'b0;
   logic [1:0] fx_grant;
   logic [0:0] fx_owner;
   logic       fx_busy, fx_xd, fx_to;

   int n_checks = 0;
   int n_errors = 0;

   vec_t rr_tab[27];
   vec_t fx_tab[10];

   always #5 clk = ~clk;

   sys_bus_arbiter #(.NREQ(2), .FIXED_PRIO(0), .TIMEOUT(4)) dut_rr (
      .clk         (clk),
      .rst         (rst),
      .req         (rr_req),
      .ready       (rr_ready),
      .grant       (rr_grant),
      .owner       (rr_owner),
      .bus_busy    (rr_busy),
      .xfer_done   (rr_xd),
      .timeout_err (rr_to)
   );

   sys_bus_arbiter #(.NREQ(2), .FIXED_PRIO(1)) dut_fx (
      .clk         (clk),
      .rst         (rst),
      .req         (fx_req),
      .ready       (fx_ready),
      .grant       (fx_grant),
      .owner       (fx_owner),
      .bus_busy    (fx_busy),
      .xfer_done   (fx_xd),
      .timeout_err (fx_to)
   );

   task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input int idx, input vec_t v,
                             input logic [1:0] g, input logic [0:0] o,
                             input logic b, input logic x, input logic t);
      check({tag, "_grant"}, idx, {6'd0, g}, {6'd0, v.gnt});
      check({tag, "_busy"},  idx, {7'd0, b}, {7'd0, |v.gnt});
      check({tag, "_xfer"},  idx, {7'd0, x}, {7'd0, v.xd});
      check({tag, "_tmo"},   idx, {7'd0, t}, {7'd0, v.to});
      if (v.gnt != 2'b00)
         check({tag, "_owner"}, idx, {7'd0, o}, {7'd0, v.gnt[1]});
   endtask

   initial begin
      // req, ready -> grant, xfer_done, timeout_err after the next rising edge
      rr_tab[0]  = '{2'b10, 1'b0, 2'b10, 1'b0, 1'b0};
      rr_tab[1]  = '{2'b10, 1'b0, 2'b10, 1'b0, 1'b0};
      rr_tab[2]  = '{2'b10, 1'b0, 2'b10, 1'b0, 1'b0};
      rr_tab[3]  = '{2'b10, 1'b1, 2'b00, 1'b1, 1'b0};
      rr_tab[4]  = '{2'b00, 1'b0, 2'b00, 1'b0, 1'b0};
      rr_tab[5]  = '{2'b00, 1'b0, 2'b00, 1'b0, 1'b0};
      rr_tab[6]  = '{2'b11, 1'b0, 2'b01, 1'b0, 1'b0};
      rr_tab[7]  = '{2'b11, 1'b1, 2'b00, 1'b1, 1'b0};
      rr_tab[8]  = '{2'b11, 1'b0, 2'b00, 1'b0, 1'b0};
      rr_tab[9]  = '{2'b11, 1'b0, 2'b10, 1'b0, 1'b0};
      rr_tab[10] = '{2'b11, 1'b1, 2'b00, 1'b1, 1'b0};
      rr_tab[11] = '{2'b11, 1'b0, 2'b00, 1'b0, 1'b0};
      rr_tab[12] = '{2'b11, 1'b0, 2'b01, 1'b0, 1'b0};
      rr_tab[13] = '{2'b11, 1'b1, 2'b00, 1'b1, 1'b0};
      rr_tab[14] = '{2'b11, 1'b1, 2'b00, 1'b0, 1'b0};
      rr_tab[15] = '{2'b11, 1'b0, 2'b10, 1'b0, 1'b0};
      rr_tab[16] = '{2'b01, 1'b0, 2'b00, 1'b0, 1'b0};
      rr_tab[17] = '{2'b01, 1'b0, 2'b00, 1'b0, 1'b0};
      rr_tab[18] = '{2'b11, 1'b0, 2'b01, 1'b0, 1'b0};
      rr_tab[19] = '{2'b11, 1'b0, 2'b01, 1'b0, 1'b0};
      rr_tab[20] = '{2'b11, 1'b0, 2'b01, 1'b0, 1'b0};
      rr_tab[21] = '{2'b11, 1'b0, 2'b01, 1'b0, 1'b0};
      rr_tab[22] = '{2'b11, 1'b0, 2'b00, 1'b0, 1'b1};
      rr_tab[23] = '{2'b11, 1'b0, 2'b00, 1'b0, 1'b0};
      rr_tab[24] = '{2'b11, 1'b0, 2'b10, 1'b0, 1'b0};
      rr_tab[25] = '{2'b11, 1'b1, 2'b00, 1'b1, 1'b0};
      rr_tab[26] = '{2'b00, 1'b0, 2'b00, 1'b0, 1'b0};

      fx_tab[0]  = '{2'b11, 1'b0, 2'b01, 1'b0, 1'b0};
      fx_tab[1]  = '{2'b11, 1'b1, 2'b00, 1'b1, 1'b0};
      fx_tab[2]  = '{2'b11, 1'b0, 2'b00, 1'b0, 1'b0};
      fx_tab[3]  = '{2'b11, 1'b0, 2'b01, 1'b0, 1'b0};
      fx_tab[4]  = '{2'b11, 1'b1, 2'b00, 1'b1, 1'b0};
      fx_tab[5]  = '{2'b11, 1'b0, 2'b00, 1'b0, 1'b0};
      fx_tab[6]  = '{2'b11, 1'b0, 2'b01, 1'b0, 1'b0};
      fx_tab[7]  = '{2'b11, 1'b1, 2'b00, 1'b1, 1'b0};
      fx_tab[8]  = '{2'b10, 1'b0, 2'b00, 1'b0, 1'b0};
      fx_tab[9]  = '{2'b10, 1'b0, 2'b10, 1'b0, 1'b0};

      repeat (3) @(posedge clk);
      #1;
      check("rst_grant", 0, {6'd0, rr_grant}, 8'd0);
      check("rst_owner", 0, {7'd0, rr_owner}, 8'd0);
      check("rst_busy",  0, {7'd0, rr_busy},  8'd0);
      check("rst_xfer",  0, {7'd0, rr_xd},    8'd0);
      check("rst_tmo",   0, {7'd0, rr_to},    8'd0);
      check("rst_fx_grant", 0, {6'd0, fx_grant}, 8'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 27; i++) begin
         rr_req   = rr_tab[i].req;
         rr_ready = rr_tab[i].rdy;
         @(posedge clk);
         #1;
         check_outs("rr", i, rr_tab[i], rr_grant, rr_owner, rr_busy, rr_xd, rr_to);
      end

      for (int i = 0; i < 10; i++) begin
         fx_req   = fx_tab[i].req;
         fx_ready = fx_tab[i].rdy;
         @(posedge clk);
         #1;
         check_outs("fx", i, fx_tab[i], fx_grant, fx_owner, fx_busy, fx_xd, fx_to);
      end
      fx_req   = 2'b00;
      fx_ready = 1'b0;

      // Asynchronous reset between clock edges while master 1 owns the bus.
      rr_req   = 2'b10;
      rr_ready = 1'b0;
      @(posedge clk);
      #1;
      check("pre_rst_grant", 0, {6'd0, rr_grant}, 8'h02);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_grant", 0, {6'd0, rr_grant}, 8'd0);
      check("async_rst_busy",  0, {7'd0, rr_busy},  8'd0);
      @(negedge clk);
      rst    = 1'b0;
      rr_req = 2'b11;
      @(posedge clk);
      #1;
      check("post_rst_grant", 0, {6'd0, rr_grant}, 8'h01);
      check("post_rst_owner", 0, {7'd0, rr_owner}, 8'd0);
      rr_req = 2'b00;
      repeat (2) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
